demux_8_32: RTL and testbench



---
 rtl/demux_8_32.sv | 92 +++++++++
 tb/tb_demux_8_32.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/demux_8_32.sv
// Byte-to-word packer: rebuilds 32-bit words from the serialized byte stream,
// pulses valid_out per completed word and frag_err per abandoned partial word.
module demux_8_32 #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int WCNT_W    = 8
) (
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic              valid_in,
  input  logic [7:0]        data_in,
  output logic              valid_out,
  output logic [31:0]       data_out,
  output logic              frag_err,
  output logic [WCNT_W-1:0] word_cnt
);

  // State encoding doubles as the index of the byte being captured.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       asm_reg, asm_next;
  logic [31:0]       merged;
  logic [31:0]       data_reg, data_next;
  logic              valid_reg, valid_next;
  logic              frag_reg, frag_next;
  logic [WCNT_W-1:0] cnt_reg, cnt_next;

  // Held bytes with the incoming byte dropped into the lane selected by state.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam int         POS = MSB_FIRST ? (3 - gi) : gi;
      localparam logic [1:0] IDX = 2'(gi);
      assign merged[POS*8 +: 8] = (state_reg == state_t'(IDX)) ? data_in
                                                                : asm_reg[POS*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    asm_next   = asm_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    frag_next  = 1'b0;
    cnt_next   = cnt_reg;
    if (valid_in) begin
      asm_next = merged;
      case (state_reg)
        IDLE:    state_next = B1;
        B1:      state_next = B2;
        B2:      state_next = B3;
        default: begin
          state_next = IDLE;
          data_next  = merged;
          valid_next = 1'b1;
          cnt_next   = cnt_reg + WCNT_W'(1);
        end
      endcase
    end else if (state_reg != IDLE) begin
      state_next = IDLE;
      frag_next  = 1'b1;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      state_reg <= IDLE;
      asm_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      frag_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      asm_reg   <= asm_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      frag_reg  <= frag_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign valid_out = valid_reg;
  assign data_out  = data_reg;
  assign frag_err  = frag_reg;
  assign word_cnt  = cnt_reg;

endmodule

// File: tb/tb_demux_8_32.sv
// Directed bench for demux_8_32: three instances (default, LSB-first,
// 2-bit counter) share one stimulus stream.
module tb_demux_8_32;

  logic        clk_4f = 1'b0;
  logic        reset_L;
  logic        valid_in;
  logic [7:0]  data_in;

  logic        m_valid, m_frag;
  logic [31:0] m_data;
  logic [7:0]  m_cnt;
  logic        l_valid, l_frag;
  logic [31:0] l_data;
  logic [7:0]  l_cnt;
  logic        w_valid, w_frag;
  logic [31:0] w_data;
  logic [1:0]  w_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int n_step   = 0;

  always #5 clk_4f = ~clk_4f;

  demux_8_32 u_msb (
    .clk_4f(clk_4f), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .valid_out(m_valid), .data_out(m_data), .frag_err(m_frag), .word_cnt(m_cnt)
  );

  demux_8_32 #(.MSB_FIRST(1'b0)) u_lsb (
    .clk_4f(clk_4f), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .valid_out(l_valid), .data_out(l_data), .frag_err(l_frag), .word_cnt(l_cnt)
  );

  demux_8_32 #(.WCNT_W(2)) u_w2 (
    .clk_4f(clk_4f), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .valid_out(w_valid), .data_out(w_data), .frag_err(w_frag), .word_cnt(w_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic v, input logic [31:0] d,
                          input logic f, input logic [7:0] c);
    chk({tag, ".valid_out"}, {31'd0, m_valid}, {31'd0, v});
    chk({tag, ".data_out"},  m_data, d);
    chk({tag, ".frag_err"},  {31'd0, m_frag}, {31'd0, f});
    chk({tag, ".word_cnt"},  {24'd0, m_cnt}, {24'd0, c});
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the capturing edge.
  task automatic step(input logic rl, input logic v, input logic [7:0] d);
    @(negedge clk_4f);
    reset_L  = rl;
    valid_in = v;
    data_in  = d;
    @(posedge clk_4f);
    #1;
    n_step++;
    $display("step %0d: reset_L=%b valid_in=%b data_in=%h -> valid_out=%b data_out=%h frag_err=%b word_cnt=%0d | lsb=%h | w2cnt=%0d",
             n_step, rl, v, d, m_valid, m_data, m_frag, m_cnt, l_data, w_cnt);
  endtask

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;

    // Reset state
    step(1'b0, 1'b0, 8'h00);
    chk_main("reset", 1'b0, 32'h0, 1'b0, 8'd0);
    chk("reset.lsb_data", l_data, 32'h0);
    chk("reset.w2_cnt", {30'd0, w_cnt}, 32'd0);

    // Test 1: AA BB CC DD
    step(1'b1, 1'b1, 8'hAA);
    chk("t1.b0_valid", {31'd0, m_valid}, 32'd0);
    step(1'b1, 1'b1, 8'hBB);
    step(1'b1, 1'b1, 8'hCC);
    chk("t1.b2_valid", {31'd0, m_valid}, 32'd0);
    step(1'b1, 1'b1, 8'hDD);
    chk_main("t1.word", 1'b1, 32'hAABBCCDD, 1'b0, 8'd1);
    chk("t1.lsb_data", l_data, 32'hDDCCBBAA);
    chk("t1.w2_cnt", {30'd0, w_cnt}, 32'd1);
    step(1'b1, 1'b0, 8'h00);
    chk_main("t1.after", 1'b0, 32'hAABBCCDD, 1'b0, 8'd1);

    // Test 2: continuous valid, two words back to back
    step(1'b1, 1'b1, 8'h11);
    step(1'b1, 1'b1, 8'h22);
    step(1'b1, 1'b1, 8'h33);
    step(1'b1, 1'b1, 8'h44);
    chk_main("t2.word1", 1'b1, 32'h11223344, 1'b0, 8'd2);
    chk("t2.lsb_data", l_data, 32'h44332211);
    step(1'b1, 1'b1, 8'hFF);
    chk_main("t2.nobubble", 1'b0, 32'h11223344, 1'b0, 8'd2);
    step(1'b1, 1'b1, 8'hFF);
    chk("t2.gap2_valid", {31'd0, m_valid}, 32'd0);
    step(1'b1, 1'b1, 8'hFF);
    chk("t2.gap3_valid", {31'd0, m_valid}, 32'd0);
    step(1'b1, 1'b1, 8'hFF);
    chk_main("t2.word2", 1'b1, 32'hFFFFFFFF, 1'b0, 8'd3);
    chk("t2.w2_cnt", {30'd0, w_cnt}, 32'd3);
    step(1'b1, 1'b0, 8'h00);
    chk_main("t2.after", 1'b0, 32'hFFFFFFFF, 1'b0, 8'd3);

    // Test 3: fragment after two bytes, then a full word
    step(1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b1, 8'hBB);
    step(1'b1, 1'b0, 8'hBB);
    chk_main("t3.frag", 1'b0, 32'hFFFFFFFF, 1'b1, 8'd3);
    step(1'b1, 1'b1, 8'h11);
    chk("t3.frag_clear", {31'd0, m_frag}, 32'd0);
    step(1'b1, 1'b1, 8'h22);
    step(1'b1, 1'b1, 8'h33);
    step(1'b1, 1'b1, 8'h44);
    chk_main("t3.word", 1'b1, 32'h11223344, 1'b0, 8'd4);
    chk("t3.w2_wrap", {30'd0, w_cnt}, 32'd0);

    // Test 4: reset mid-word has priority over a valid byte
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b1, 8'hBB);
    step(1'b1, 1'b1, 8'hCC);
    step(1'b0, 1'b1, 8'h55);
    chk_main("t4.reset", 1'b0, 32'h0, 1'b0, 8'd0);
    chk("t4.w2_cnt", {30'd0, w_cnt}, 32'd0);
    step(1'b1, 1'b1, 8'h11);
    chk_main("t4.b0", 1'b0, 32'h0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'h22);
    step(1'b1, 1'b1, 8'h33);
    chk("t4.b2_frag", {31'd0, m_frag}, 32'd0);
    step(1'b1, 1'b1, 8'h44);
    chk_main("t4.word", 1'b1, 32'h11223344, 1'b0, 8'd1);
    chk("t4.lsb_data", l_data, 32'h44332211);
    chk("t4.w2_cnt1", {30'd0, w_cnt}, 32'd1);

    // Test 6: counter sequence on the 2-bit instance, idle gaps harmless
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b1, 8'h02);
    step(1'b1, 1'b1, 8'h03);
    step(1'b1, 1'b1, 8'h04);
    chk_main("t6.word2", 1'b1, 32'h01020304, 1'b0, 8'd2);
    chk("t6.w2_cnt2", {30'd0, w_cnt}, 32'd2);
    step(1'b1, 1'b0, 8'h5A);
    chk_main("t6.idle_gap", 1'b0, 32'h01020304, 1'b0, 8'd2);
    step(1'b1, 1'b0, 8'hA5);
    chk("t6.idle_gap2_frag", {31'd0, m_frag}, 32'd0);
    step(1'b1, 1'b1, 8'hA0);
    step(1'b1, 1'b1, 8'hB0);
    step(1'b1, 1'b1, 8'hC0);
    step(1'b1, 1'b1, 8'hD0);
    chk_main("t6.word3", 1'b1, 32'hA0B0C0D0, 1'b0, 8'd3);
    chk("t6.w2_cnt3", {30'd0, w_cnt}, 32'd3);
    chk("t6.lsb_data", l_data, 32'hD0C0B0A0);
    step(1'b1, 1'b1, 8'hE1);
    step(1'b1, 1'b1, 8'hE2);
    step(1'b1, 1'b1, 8'hE3);
    step(1'b1, 1'b1, 8'hE4);
    chk_main("t6.word4", 1'b1, 32'hE1E2E3E4, 1'b0, 8'd4);
    chk("t6.w2_wrap", {30'd0, w_cnt}, 32'd0);
    chk("t6.w2_valid", {31'd0, w_valid}, 32'd1);
    chk("t6.w2_data", w_data, 32'hE1E2E3E4);
    step(1'b1, 1'b0, 8'h00);
    chk_main("t6.after", 1'b0, 32'hE1E2E3E4, 1'b0, 8'd4);
    chk("t6.lsb_frag", {31'd0, l_frag}, 32'd0);
    chk("t6.lsb_cnt", {24'd0, l_cnt}, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
